shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-bit shift controller that sits around the 16-bit single-bit shifter unit in the ALU.
- Latches an operand, a shift amount (0..15) and a shift mode. It then drives the shifter's op_x/op_en inputs once per cycle and feeds op_out back into an accumulator until the requested number of 1-bit shifts is done.
- Presents the final value with a one-cycle done pulse. Provides SLL/SRL/SRA by N bits without a barrel shifter.

Parameters:
- WIDTH, 16, data width; must match the shifter unit.
- CNT_W, 4, shift-amount width; maximum amount is 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted on a rising edge when start=1 and ready=1.
- mode  input  2  00=SLL, 01=SRL, 10=SRA, 11=pass-through.
- data_in  input  WIDTH  operand, sampled at acceptance.
- amount  input  CNT_W  shift count, sampled at acceptance.
- ready  output  1  high only in IDLE; combinational from state.
- sh_x  output  WIDTH  to shifter op_x; equals accumulator.
- sh_en  output  3  to shifter op_en.
- sh_out  input  WIDTH  from shifter op_out.
- result  output  WIDTH  registered final value; held until the next completion.
- done  output  1  registered; one-cycle pulse when result updates.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; acc, count, result=0; done=0.
  - Consequently ready=1, sh_en=000, sh_x=0.
- States: IDLE, SHIFT, DONE.
- IDLE, on acceptance at edge E0:
  - acc<=data_in; mode latched.
  - count<=amount, or count<=0 if mode=11.
  - Next state is SHIFT if the loaded count is nonzero, else DONE.
- sh_en mapping:
  - In SHIFT: SLL->001, SRL->010, SRA->011.
  - In IDLE and DONE: sh_en=000, which makes the shifter output 0 and keeps it quiet.
- SHIFT, each edge:
  - acc<=sh_out; count<=count-1.
  - When count==1 at the edge, next state is DONE and result<=sh_out.
- Entering DONE with zero count: result<=acc (i.e. data_in).
- done is asserted for exactly the cycle the state is DONE; next edge returns to IDLE unconditionally.
- Latency for amount=N:
  - done is high in the cycle after edge E_N (E_0 when N=0).
  - ready is low from after E0 until after E_(N+1).
  - Back-to-back requests start no sooner than one cycle after done.
- start while ready=0 (SHIFT or DONE) is ignored; the request is not queued.
- data_in, amount and mode changes after acceptance have no effect.
- SRA propagates bit WIDTH-1 each step: 15 steps of 0x8000 gives 0xFFFF.
- SRL/SLL by 15 leave a single bit or zero.
- mode=11 with any amount: result=data_in after one DONE cycle, and no shifter activity.
- Reset mid-SHIFT aborts the operation:
  - result clears to 0; done is not pulsed.
  - First accept is possible on the first edge after rst deasserts.
- Count arithmetic is unsigned CNT_W; it never underflows because exit occurs at count==1.

Test Plan:
- SLL, data_in=0x0001, amount=4 at E0 -> sh_en=001 for 4 cycles; done after E4; result=0x0010; ready high after E5.
- SRA, data_in=0x8000, amount=15 -> result=0xFFFF, done after E15. SRL with the same inputs -> result=0x0001.
- amount=0, mode=00, data_in=0xA5C3 -> done in the cycle after E0, result=0xA5C3, sh_en stays 000. mode=11, amount=7, data_in=0x1234 -> result=0x1234, done after E0.
- Start a second request (0xFFFF, SLL, 3) while the first (0x00F0, SRL, 4) is in SHIFT -> second ignored; result=0x000F; then re-issue the second after done -> result=0xFFF8.
- Assert rst two cycles into an SRL-by-8 of 0xFF00 -> immediately result=0, done=0, ready=1, sh_en=000; a new SLL-by-1 of 0x0003 after release -> result=0x0006.
- Back-to-back: accept in the first cycle ready returns -> no lost or duplicated done pulse; result changes only on done cycles.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Bus between the shift sequencer, its requester and the ALU's 1-bit shifter unit.
// The master is the environment (requester plus shifter); the slave is the sequencer.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic [CNT_W-1:0] amount;
  logic             ready;
  logic [WIDTH-1:0] sh_x;
  logic [2:0]       sh_en;
  logic [WIDTH-1:0] sh_out;
  logic [WIDTH-1:0] result;
  logic             done;

  modport master (
    output start, mode, data_in, amount, sh_out,
    input  ready, sh_x, sh_en, result, done
  );

  modport slave (
    input  start, mode, data_in, amount, sh_out,
    output ready, sh_x, sh_en, result, done
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit SLL/SRL/SRA controller that iterates the ALU's single-bit shifter,
// one step per cycle, and presents the final value with a one-cycle done pulse.
module shift_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input logic            clk,
  input logic            rst,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] count;
  logic [1:0]       mode_q;
  logic             done_q;

  logic             accept;
  logic [CNT_W-1:0] load_cnt;
  logic             last_step;

  assign accept    = (state == IDLE) && bus.start;
  // Pass-through loads a zero count so it goes straight to DONE with no shifter activity.
  assign load_cnt  = (bus.mode == 2'b11) ? '0 : bus.amount;
  assign last_step = (state == SHIFT) && (count == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (load_cnt != '0) ? SHIFT : DONE;
      SHIFT:   if (last_step) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state == IDLE);
    bus.sh_en = 3'b000;
    if (state == SHIFT) begin
      case (mode_q)
        2'b00:   bus.sh_en = 3'b001;
        2'b01:   bus.sh_en = 3'b010;
        2'b10:   bus.sh_en = 3'b011;
        default: bus.sh_en = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      mode_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_nx == DONE);
      if (accept) begin
        acc    <= bus.data_in;
        mode_q <= bus.mode;
        count  <= load_cnt;
        // Zero-count requests complete at acceptance, so the operand is the result.
        if (load_cnt == '0) result_q <= bus.data_in;
      end else if (state == SHIFT) begin
        acc   <= bus.sh_out;
        count <= count - CNT_W'(1);
        if (last_step) result_q <= bus.sh_out;
      end
    end
  end

  assign bus.sh_x   = acc;
  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: models the 1-bit shifter unit, applies a
// vector table, hand-written corner sequences and random requests against a reference.
module tb_shift_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the ALU's single-bit shifter unit.
  function automatic logic [15:0] shifter(input logic [15:0] x, input logic [2:0] en);
    case (en)
      3'b001:  return {x[14:0], 1'b0};
      3'b010:  return {1'b0, x[15:1]};
      3'b011:  return {x[15], x[15:1]};
      default: return 16'h0000;
    endcase
  endfunction

  assign bus.sh_out = shifter(bus.sh_x, bus.sh_en);

  // Reference: the whole N-bit shift in one arithmetic step.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] m,
                                            input logic [3:0] a);
    logic signed [15:0] s;
    s = d;
    case (m)
      2'b00:   return d << a;
      2'b01:   return d >> a;
      2'b10:   return 16'(s >>> a);
      default: return d;
    endcase
  endfunction

  function automatic logic [2:0] en_code(input logic [1:0] m);
    case (m)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request at the current negedge (ready must be high) and follow it to
  // completion. With noise set, start stays asserted with junk while busy.
  task automatic run_op(input logic [15:0] d, input logic [1:0] m, input logic [3:0] a,
                        input logic [15:0] exp_res, input int exp_lat, input bit noise);
    logic [15:0] prev;
    int          lat;
    check("ready_before_start", 32'(bus.ready), 32'd1);
    prev        = bus.result;
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.mode    = m;
    bus.amount  = a;
    @(posedge clk);
    @(negedge clk);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      check("busy_ready", 32'(bus.ready), 32'd0);
      check("busy_result_hold", 32'(bus.result), 32'(prev));
      check("busy_sh_en", 32'(bus.sh_en), (k < exp_lat) ? 32'(en_code(m)) : 32'd0);
      if (k < exp_lat) check("busy_sh_x", 32'(bus.sh_x), 32'(ref_shift(d, m, 4'(k))));
      bus.start   = noise;
      bus.data_in = 16'($urandom);
      bus.mode    = 2'($urandom);
      bus.amount  = 4'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_latency", 32'(lat), 32'(exp_lat));
    check("done_result", 32'(bus.result), 32'(exp_res));
    check("done_ready", 32'(bus.ready), 32'd0);
    check("done_sh_en", 32'(bus.sh_en), 32'd0);
    @(negedge clk);
    check("after_done_ready", 32'(bus.ready), 32'd1);
    check("after_done_pulse", 32'(bus.done), 32'd0);
    check("after_done_result", 32'(bus.result), 32'(exp_res));
  endtask

  typedef struct {
    logic [15:0] d;
    logic [1:0]  m;
    logic [3:0]  a;
    logic [15:0] exp_res;
    int          lat;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    tbl[0] = '{16'h0001, 2'b00, 4'd4,  16'h0010, 4};
    tbl[1] = '{16'h8000, 2'b10, 4'd15, 16'hFFFF, 15};
    tbl[2] = '{16'h8000, 2'b01, 4'd15, 16'h0001, 15};
    tbl[3] = '{16'hA5C3, 2'b00, 4'd0,  16'hA5C3, 0};
    tbl[4] = '{16'h1234, 2'b11, 4'd7,  16'h1234, 0};
    tbl[5] = '{16'h0001, 2'b00, 4'd15, 16'h8000, 15};
    tbl[6] = '{16'hF0F0, 2'b10, 4'd1,  16'hF878, 1};
    tbl[7] = '{16'hC003, 2'b01, 4'd2,  16'h3000, 2};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.mode    = 2'b00;
    bus.data_in = '0;
    bus.amount  = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_sh_en", 32'(bus.sh_en), 32'd0);
    check("reset_sh_x", 32'(bus.sh_x), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].d, tbl[i].m, tbl[i].a, tbl[i].exp_res, tbl[i].lat, 1'b0);

    // Start held high throughout the first request must not queue a second one.
    run_op(16'h00F0, 2'b01, 4'd4, 16'h000F, 4, 1'b1);
    run_op(16'hFFFF, 2'b00, 4'd3, 16'hFFF8, 3, 1'b0);

    // Asynchronous reset two cycles into a shift aborts it.
    bus.start   = 1'b1;
    bus.data_in = 16'hFF00;
    bus.mode    = 2'b01;
    bus.amount  = 4'd8;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_sh_en", 32'(bus.sh_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0003, 2'b00, 4'd1, 16'h0006, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [15:0] d;
      logic [1:0]  m;
      logic [3:0]  a;
      d = 16'($urandom);
      m = 2'($urandom);
      a = 4'($urandom);
      run_op(d, m, a, ref_shift(d, m, a), (m == 2'b11) ? 0 : int'(a), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
